// File: rtl/unidad_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake
// and drives the IF/ID register, with a one-entry skid for lossless stalls.
module unidad_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] SalAdd,
    output logic [31:0] SalInst,
    output logic        SalVal
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] add_q, add_d;
    logic [31:0] inst_q, inst_d;
    logic        val_q, val_d;
    logic [31:0] skid_add_q, skid_add_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] pc_inc_s;

    assign pc_inc_s = pc_q + PC_STEP;

    // Next-state logic; redirect outranks stall and every state transition.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        add_d       = add_q;
        inst_d      = inst_q;
        val_d       = val_q;
        skid_add_d  = skid_add_q;
        skid_inst_d = skid_inst_q;
        skid_vld_d  = skid_vld_q;

        if (redir) begin
            pc_d        = redir_pc & 32'hFFFF_FFFC;
            val_d       = 1'b0;
            skid_add_d  = 32'h0000_0000;
            skid_inst_d = 32'h0000_0000;
            skid_vld_d  = 1'b0;
            if ((state_q != ST_HOLD) && !mem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (mem_ack) begin
                        pc_d = pc_inc_s;
                        if (!val_q || !stall) begin
                            inst_d = mem_rdata;
                            add_d  = pc_inc_s;
                            val_d  = 1'b1;
                        end else begin
                            skid_inst_d = mem_rdata;
                            skid_add_d  = pc_inc_s;
                            skid_vld_d  = 1'b1;
                            state_d     = ST_HOLD;
                        end
                    end else if (!stall) begin
                        val_d = 1'b0;
                    end else begin
                        val_d = val_q;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        inst_d      = skid_inst_q;
                        add_d       = skid_add_q;
                        val_d       = skid_vld_q;
                        skid_vld_d  = 1'b0;
                        state_d     = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    // Returning word belongs to the pre-redirect stream.
                    if (mem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end

        req_d  = (state_d != ST_HOLD);
        addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b1;
            add_q       <= 32'h0000_0000;
            inst_q      <= 32'h0000_0000;
            val_q       <= 1'b0;
            skid_add_q  <= 32'h0000_0000;
            skid_inst_q <= 32'h0000_0000;
            skid_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            add_q       <= add_d;
            inst_q      <= inst_d;
            val_q       <= val_d;
            skid_add_q  <= skid_add_d;
            skid_inst_q <= skid_inst_d;
            skid_vld_q  <= skid_vld_d;
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign SalAdd   = add_q;
    assign SalInst  = inst_q;
    assign SalVal   = val_q;

endmodule
